// File: rtl/fetch_decode_unit_if.sv
// fetch_decode_unit_if: instruction-memory read bus with req/ack handshake
// master drives req/addr and samples ack/rdata; slave is the memory side.
interface fetch_decode_unit_if #(parameter int ADDR_W = 8);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [15:0]       rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: PC owner, instruction fetch over req/ack and IR field split
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   fetch_en_i               control FSM wants a new instruction
//   instr_consume_i          current instruction taken (pulse)
//   pc_load_i, pc_target_i   PC redirect
//   imem                     instruction-memory bus (master side)
//   instr_valid_o            decoded fields valid
//   op_code_o..op3_o, imm_o  IR nibbles and sign-extended op1
//   pc_o                     next fetch address
//   fetch_err_o              sticky ack-timeout flag
module fetch_decode_unit #(
  parameter int              ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int              ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en_i,
  input  logic              instr_consume_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_target_i,
  fetch_decode_unit_if.master imem,
  output logic              instr_valid_o,
  output logic [3:0]        op_code_o,
  output logic [3:0]        op1_o,
  output logic [3:0]        op2_o,
  output logic [3:0]        op3_o,
  output logic [15:0]       imm_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d, req_q, req_d, flush_q, flush_d, err_q, err_d;
  logic              start, gap, take, discard, timeout, waiting;
  assign start   = state_q == IDLE && fetch_en_i && !valid_q;
  // req low while in REQ is the one-cycle gap before reissuing after a flush
  assign gap     = state_q == REQ && !req_q;
  assign take    = req_q && imem.ack;
  // a redirect arriving with the ack also invalidates the returned word
  assign discard = take && (flush_q || pc_load_i);
  assign timeout = req_q && !imem.ack && cnt_q + 8'd1 == 8'(ACK_TIMEOUT);
  assign waiting = req_q && !imem.ack && !timeout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? REQ : IDLE;
      REQ:     state_d = take && !discard ? VALID : timeout ? IDLE : REQ;
      VALID:   state_d = instr_consume_i ? IDLE : VALID;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pc_d    = pc_load_i ? pc_target_i : take && !discard ? pc_q + 1'b1 : pc_q;
    req_d   = start || gap || waiting;
    // address is captured only when a request is launched, so it stays stable while req is high
    addr_d  = start || gap ? pc_d : addr_q;
    ir_d    = take && !discard ? imem.rdata : ir_q;
    valid_d = take && !discard ? 1'b1 : state_q == VALID && instr_consume_i ? 1'b0 : valid_q;
    flush_d = waiting && (flush_q || pc_load_i);
    cnt_d   = req_q && !imem.ack ? cnt_q + 8'd1 : 8'd0;
    err_d   = err_q || timeout;
  end
  assign imem.req      = req_q;
  assign imem.addr     = addr_q;
  assign instr_valid_o = valid_q;
  assign op_code_o     = ir_q[15:12];
  assign op1_o         = ir_q[11:8];
  assign op2_o         = ir_q[7:4];
  assign op3_o         = ir_q[3:0];
  assign imm_o         = {{12{ir_q[11]}}, ir_q[11:8]};
  assign pc_o          = pc_q;
  assign fetch_err_o   = err_q;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed checks of fetch, flush, timeout, wrap and reset
module tb_fetch_decode_unit;
  logic        clk = 1'b0;
  logic        rst_n, fetch_en, consume, pc_load;
  logic [7:0]  target, pc;
  logic        valid, err;
  logic [3:0]  opc, op1, op2, op3;
  logic [15:0] imm;
  int          n_tests = 0, n_fail = 0;
  fetch_decode_unit_if #(.ADDR_W(8)) bus ();
  fetch_decode_unit #(.ADDR_W(8), .RESET_PC(8'h10), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .instr_consume_i(consume),
    .pc_load_i(pc_load), .pc_target_i(target), .imem(bus.master),
    .instr_valid_o(valid), .op_code_o(opc), .op1_o(op1), .op2_o(op2), .op3_o(op3),
    .imm_o(imm), .pc_o(pc), .fetch_err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic issue();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
  endtask
  task automatic ack(input logic [15:0] w);
    bus.ack = 1'b1;
    bus.rdata = w;
    tick();
    bus.ack = 1'b0;
  endtask
  task automatic consume_it();
    consume = 1'b1;
    tick();
    consume = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; consume = 1'b0; pc_load = 1'b0; target = '0;
    bus.ack = 1'b0; bus.rdata = '0;
    tick(); tick();
    chk("rst_pc", pc, 8'h10);
    chk("rst_addr", bus.addr, 8'h10);
    chk("rst_req", bus.req, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_imm", imm, 0);
    rst_n = 1'b1;
    tick();
    issue();
    chk("t1_req", bus.req, 1);
    chk("t1_addr", bus.addr, 8'h10);
    ack(16'h1234);
    chk("t1_valid", valid, 1);
    chk("t1_fields", {opc, op1, op2, op3}, 16'h1234);
    chk("t1_imm", imm, 16'h0002);
    chk("t1_pc", pc, 8'h11);
    chk("t1_req_off", bus.req, 0);
    consume_it();
    chk("t1_consumed", valid, 0);
    issue();
    chk("t2_addr", bus.addr, 8'h11);
    ack(16'h1F56);
    chk("t2_imm", imm, 16'hFFFF);
    fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", valid, 1);
      chk("t2_hold_fields", {opc, op1, op2, op3}, 16'h1F56);
      chk("t2_hold_noreq", bus.req, 0);
    end
    fetch_en = 1'b0;
    consume_it();
    issue();
    chk("t3_addr0", bus.addr, 8'h12);
    pc_load = 1'b1; target = 8'h40;
    tick();
    pc_load = 1'b0;
    chk("t3_pc", pc, 8'h40);
    chk("t3_addr_stable", bus.addr, 8'h12);
    tick();
    ack(16'hAAAA);
    chk("t3_discard_valid", valid, 0);
    chk("t3_gap", bus.req, 0);
    tick();
    chk("t3_reissue_req", bus.req, 1);
    chk("t3_reissue_addr", bus.addr, 8'h40);
    ack(16'h2345);
    chk("t3_valid", valid, 1);
    chk("t3_fields", {opc, op1, op2, op3}, 16'h2345);
    chk("t3_pc_inc", pc, 8'h41);
    consume_it();
    issue();
    chk("t4_addr0", bus.addr, 8'h41);
    pc_load = 1'b1; target = 8'h05;
    ack(16'hBEEF);
    pc_load = 1'b0;
    chk("t4_pc", pc, 8'h05);
    chk("t4_valid", valid, 0);
    chk("t4_gap", bus.req, 0);
    tick();
    chk("t4_reissue_addr", bus.addr, 8'h05);
    chk("t4_reissue_req", bus.req, 1);
    ack(16'h7001);
    chk("t4_fields", {opc, op1, op2, op3}, 16'h7001);
    chk("t4_pc_inc", pc, 8'h06);
    consume_it();
    issue();
    for (int i = 0; i < 14; i++) tick();
    chk("t5_req_still", bus.req, 1);
    chk("t5_err_not_yet", err, 0);
    tick();
    chk("t5_req_drop", bus.req, 0);
    chk("t5_err", err, 1);
    chk("t5_pc_same", pc, 8'h06);
    issue();
    chk("t5_retry_req", bus.req, 1);
    chk("t5_retry_addr", bus.addr, 8'h06);
    ack(16'h0000);
    chk("t5_retry_valid", valid, 1);
    chk("t5_err_sticky", err, 1);
    chk("t5_pc_inc", pc, 8'h07);
    consume_it();
    pc_load = 1'b1; target = 8'hFF;
    tick();
    pc_load = 1'b0;
    chk("t6_pc_load_idle", pc, 8'hFF);
    issue();
    chk("t6_addr", bus.addr, 8'hFF);
    ack(16'h8800);
    chk("t6_wrap", pc, 8'h00);
    chk("t6_imm", imm, 16'hFFF8);
    consume_it();
    issue();
    chk("t7_req", bus.req, 1);
    #2 rst_n = 1'b0;
    #1 chk("t7_async_req", bus.req, 0);
    bus.ack = 1'b1; bus.rdata = 16'hCAFE;
    tick();
    chk("t7_pc", pc, 8'h10);
    chk("t7_addr", bus.addr, 8'h10);
    chk("t7_valid", valid, 0);
    chk("t7_err", err, 0);
    chk("t7_imm", imm, 0);
    chk("t7_fields", {opc, op1, op2, op3}, 0);
    bus.ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t7_idle", bus.req, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
